// File: rtl/xgmac_rx_packet_fifo.sv
// Store-and-forward RX packet FIFO: commits whole frames only, drops bad/overflowing frames.
// Optional frame statistics ports are built when RX_FIFO_STATS_EN is defined.
module xgmac_rx_packet_fifo #(
  parameter int unsigned ADDR_WIDTH      = 9,
  parameter bit          DROP_BAD_FRAMES = 1'b1
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        drop_pulse
`ifdef RX_FIFO_STATS_EN
  ,
  output logic [31:0] stat_good_frames,
  output logic [31:0] stat_dropped_frames
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {SYNC, IDLE, WRITE, DROP} wr_state_t;

  wr_state_t             state;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   wr_commit;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [73:0]           mem [0:DEPTH-1];

  logic full;
  logic wr_en;
  logic bad_drop;
  logic commit;
  logic rd_load;
  logic store_tuser;

  always_comb begin
    full        = (wr_ptr - rd_ptr) == PTR_FULL;
    wr_en       = s_axis_tvalid && ((state == IDLE) || (state == WRITE)) && !full;
    bad_drop    = s_axis_tuser && DROP_BAD_FRAMES;
    commit      = wr_en && s_axis_tlast && !bad_drop;
    // tuser is only meaningful on tlast and never reaches the output when bad frames are dropped
    store_tuser = s_axis_tuser && s_axis_tlast && !DROP_BAD_FRAMES;
    rd_load     = (rd_ptr != wr_commit) && (!m_axis_tvalid || m_axis_tready);
  end

  always_ff @(posedge clk156) begin
    if (wr_en)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {store_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state      <= SYNC;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        SYNC: begin
          if (!s_axis_tvalid || s_axis_tlast)
            state <= IDLE;
        end
        IDLE, WRITE: begin
          if (s_axis_tvalid) begin
            if (full) begin
              wr_ptr <= wr_commit;
              if (s_axis_tlast) begin
                drop_pulse <= 1'b1;
                state      <= IDLE;
              end else begin
                state <= DROP;
              end
            end else if (s_axis_tlast) begin
              if (bad_drop) begin
                wr_ptr     <= wr_commit;
                drop_pulse <= 1'b1;
              end else begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                wr_commit <= wr_ptr + PTR_ONE;
              end
              state <= IDLE;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              state  <= WRITE;
            end
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            drop_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  // Output register doubles as the prefetch stage: it refills on the same edge it is consumed.
  always_ff @(posedge clk156) begin
    if (reset) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (rd_load) begin
      rd_ptr        <= rd_ptr + PTR_ONE;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk156) begin
    if (rd_load)
      {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

`ifdef RX_FIFO_STATS_EN
  always_ff @(posedge clk156) begin
    if (reset) begin
      stat_good_frames    <= '0;
      stat_dropped_frames <= '0;
    end else begin
      if (commit && (stat_good_frames != '1))
        stat_good_frames <= stat_good_frames + 32'd1;
      if (drop_pulse && (stat_dropped_frames != '1))
        stat_dropped_frames <= stat_dropped_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xgmac_rx_packet_fifo.sv
// Scoreboard bench for xgmac_rx_packet_fifo (16-beat FIFO); stat checks active with RX_FIFO_STATS_EN.
module tb_xgmac_rx_packet_fifo;

  localparam int unsigned AW       = 4;
  localparam bit          DROP_BAD = 1'b1;

  logic        clk156 = 1'b0;
  logic        reset  = 1'b1;
  logic [63:0] s_axis_tdata  = '0;
  logic [7:0]  s_axis_tkeep  = '0;
  logic        s_axis_tuser  = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast  = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        drop_pulse;
`ifdef RX_FIFO_STATS_EN
  logic [31:0] stat_good_frames;
  logic [31:0] stat_dropped_frames;
`endif

  xgmac_rx_packet_fifo #(.ADDR_WIDTH(AW), .DROP_BAD_FRAMES(DROP_BAD)) dut (
    .clk156(clk156), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .drop_pulse(drop_pulse)
`ifdef RX_FIFO_STATS_EN
    , .stat_good_frames(stat_good_frames), .stat_dropped_frames(stat_dropped_frames)
`endif
  );

  always #5 clk156 = ~clk156;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int drops_seen = 0;
  int drops_exp = 0;
  int stat_good_exp = 0;
  int stat_drop_exp = 0;
  int first_valid_cyc = -1;
  int tlast_cyc = 0;
  int ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [74:0] prev_out = '0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk156) cyc++;

  initial begin
    logic tog = 1'b0;
    forever begin
      @(posedge clk156);
      #1;
      tog = ~tog;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = tog;
      endcase
    end
  end

  always @(negedge clk156) begin
    logic [74:0] cur;
    beat_t e;
    cur = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (!reset) begin
      if (prev_stall)
        check("hold_stable", 80'(cur), 80'(prev_out));
      if (m_axis_tvalid && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 80'(exp_q.size()), 80'(1));
        end else begin
          e = exp_q.pop_front();
          check("beat", 80'({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 80'(e));
        end
      end
      if (drop_pulse) drops_seen++;
    end
    prev_stall = !reset && m_axis_tvalid && !m_axis_tready;
    prev_out   = cur;
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    @(posedge clk156);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk156);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input logic [63:0] base, input logic [7:0] last_keep,
                            input bit bad, input bit expect_out);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.last = (i == len - 1);
      b.keep = b.last ? last_keep : 8'hFF;
      b.data = base + 64'(i);
      b.user = b.last && bad && !DROP_BAD;
      drive_beat(b.data, b.keep, b.last, b.last && bad);
      if (b.last) tlast_cyc = cyc;
      if (expect_out) exp_q.push_back(b);
    end
    if (expect_out) stat_good_exp++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk156);
    check(tag, 80'(exp_q.size()), 80'(0));
    repeat (5) @(posedge clk156);
    check({tag, "_drops"}, 80'(drops_seen), 80'(drops_exp));
  endtask

  task automatic check_stats(input string tag);
`ifdef RX_FIFO_STATS_EN
    check({tag, "_good"}, 80'(stat_good_frames), 80'(stat_good_exp));
    check({tag, "_dropped"}, 80'(stat_dropped_frames), 80'(stat_drop_exp));
`else
    if (tag.len() == 0) $display("empty stats tag");
`endif
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    check("reset_tvalid", 80'(m_axis_tvalid), 80'(0));
    check("reset_drop", 80'(drop_pulse), 80'(0));
    check_stats("reset");
    @(posedge clk156);
    #1;
    reset = 1'b0;
    idle(3);

    // 1: good 8-beat frame, data 0..7
    first_valid_cyc = -1;
    send_frame(8, 64'd0, 8'h0F, 1'b0, 1'b1);
    idle(1);
    drain("s1_drain");
    lat = first_valid_cyc - (tlast_cyc + 1);
    check("s1_latency_ok", 80'(lat >= 1 && lat <= 2), 80'(1));

    // 2: bad 5-beat frame then good 3-beat frame
    send_frame(5, 64'h200, 8'hFF, 1'b1, !DROP_BAD);
    if (DROP_BAD) begin drops_exp++; stat_drop_exp++; end
    send_frame(3, 64'h300, 8'h03, 1'b0, 1'b1);
    idle(1);
    drain("s2_drain");

    // 3: stalled output, oversize frame overflows, following frame survives
    ready_mode = 1;
    idle(2);
    send_frame(20, 64'h400, 8'hFF, 1'b0, 1'b0);
    drops_exp++; stat_drop_exp++;
    send_frame(4, 64'h500, 8'h01, 1'b0, 1'b1);
    idle(3);
    check("s3_stalled_drops", 80'(drops_seen), 80'(drops_exp));
    check_stats("s3_stats");
    ready_mode = 0;
    drain("s3_drain");

    // 4: back-to-back frames with alternating ready
    ready_mode = 2;
    send_frame(6, 64'h600, 8'h3F, 1'b0, 1'b1);
    send_frame(6, 64'h700, 8'h7F, 1'b0, 1'b1);
    idle(1);
    drain("s4_drain");
    ready_mode = 0;
    idle(2);

    // 5: reset during beat 3 of a 6-beat frame
    drive_beat(64'h800, 8'hFF, 1'b0, 1'b0);
    drive_beat(64'h801, 8'hFF, 1'b0, 1'b0);
    drive_beat(64'h802, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    drive_beat(64'h803, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    drive_beat(64'h804, 8'hFF, 1'b0, 1'b0);
    drive_beat(64'h805, 8'hFF, 1'b1, 1'b0);
    stat_good_exp = 0;
    stat_drop_exp = 0;
    idle(1);
    send_frame(4, 64'h900, 8'h0F, 1'b0, 1'b1);
    idle(1);
    drain("s5_drain");
    check_stats("s5_stats");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
